// File: rtl/pair_diff_engine_if.sv
// pair_diff_engine_if
// Bundles the load, control, status and result-read signals of pair_diff_engine.
//   master : drives load_we/load_addr/load_data, start, mode, rd_addr;
//            observes busy, done, neg_count, rd_data
//   slave  : the engine side (mirror of master)
// DW is the data width, DEPTH_A the operand memory depth (power of two, >= 4).
interface pair_diff_engine_if #(
  parameter int DW      = 8,
  parameter int DEPTH_A = 8
) ();
  localparam int AW = $clog2(DEPTH_A);

  logic          load_we;
  logic [AW-1:0] load_addr;
  logic [DW-1:0] load_data;
  logic          start;
  logic          mode;
  logic          busy;
  logic          done;
  logic [AW-1:0] neg_count;
  logic [AW-2:0] rd_addr;
  logic [DW-1:0] rd_data;

  modport master (
    output load_we, load_addr, load_data, start, mode, rd_addr,
    input  busy, done, neg_count, rd_data
  );

  modport slave (
    input  load_we, load_addr, load_data, start, mode, rd_addr,
    output busy, done, neg_count, rd_data
  );
endinterface

// File: rtl/pair_diff_engine.sv
// pair_diff_engine
// Walks operand pairs (A[2i], A[2i+1]) of a loadable operand memory and writes
// one result per pair into a result memory: absolute difference (mode 0) or
// saturating sum (mode 1). Also counts pairs whose first operand is smaller.
// Ports:
//   clk   : rising-edge clock
//   reset : asynchronous, active-low reset
//   bus   : pair_diff_engine_if.slave (load port, start/mode, busy/done,
//           neg_count, registered result read port)
module pair_diff_engine #(
  parameter int DW      = 8,
  parameter int DEPTH_A = 8
) (
  input  logic               clk,
  input  logic               reset,
  pair_diff_engine_if.slave  bus
);
  localparam int AW    = $clog2(DEPTH_A);
  localparam int PAIRS = DEPTH_A / 2;
  localparam int IW    = AW - 1;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_A,
    FETCH_B,
    EXEC,
    DONE
  } state_t;

  state_t        state;
  logic [IW-1:0] pair_idx;
  logic          mode_q;
  logic [DW-1:0] ra;
  logic [DW-1:0] a_q;
  logic          busy_q;
  logic          done_q;
  logic [AW-1:0] neg_q;
  logic [DW-1:0] rd_q;

  logic [DW-1:0] mem_a [DEPTH_A];
  logic [DW-1:0] mem_b [PAIRS];

  logic [AW-1:0] a_addr;
  logic [DW:0]   sum;
  logic [DW-1:0] result;
  logic          first_smaller;
  logic          last_pair;

  assign bus.busy      = busy_q;
  assign bus.done      = done_q;
  assign bus.neg_count = neg_q;
  assign bus.rd_data   = rd_q;

  // Operand address and pair arithmetic. The low address bit selects the
  // second operand only while FETCH_B is presenting it; a_q then holds the
  // second operand throughout EXEC while ra holds the first.
  always_comb begin
    a_addr        = {pair_idx, (state == FETCH_B)};
    sum           = {1'b0, ra} + {1'b0, a_q};
    first_smaller = (ra < a_q);
    last_pair     = (pair_idx == {IW{1'b1}});
    if (mode_q) begin
      result = sum[DW] ? {DW{1'b1}} : sum[DW-1:0];
    end else begin
      result = (ra >= a_q) ? (ra - a_q) : (a_q - ra);
    end
  end

  // Memories are never reset. The operand read is synchronous (one cycle),
  // loads are only accepted while idle, and results land in EXEC.
  always_ff @(posedge clk) begin
    a_q <= mem_a[a_addr];
    if (state == IDLE && bus.load_we) begin
      mem_a[bus.load_addr] <= bus.load_data;
    end
    if (state == EXEC) begin
      mem_b[pair_idx] <= result;
    end
  end

  // Controller with registered busy/done. The result read port is registered
  // here too so that it clears with reset; a read of the word being written
  // in EXEC returns the old contents.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      neg_q    <= '0;
      rd_q     <= '0;
      ra       <= '0;
      pair_idx <= '0;
      mode_q   <= 1'b0;
    end else begin
      rd_q   <= mem_b[bus.rd_addr];
      done_q <= 1'b0;
      case (state)
        IDLE: begin
          if (bus.start) begin
            mode_q   <= bus.mode;
            pair_idx <= '0;
            neg_q    <= '0;
            busy_q   <= 1'b1;
            state    <= FETCH_A;
          end
        end
        FETCH_A: begin
          state <= FETCH_B;
        end
        FETCH_B: begin
          ra    <= a_q;
          state <= EXEC;
        end
        EXEC: begin
          if (first_smaller) begin
            neg_q <= neg_q + 1'b1;
          end
          if (last_pair) begin
            busy_q <= 1'b0;
            done_q <= 1'b1;
            state  <= DONE;
          end else begin
            pair_idx <= pair_idx + 1'b1;
            state    <= FETCH_A;
          end
        end
        DONE: begin
          state <= IDLE;
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end
endmodule
